// File: rtl/mm_frame_feeder_pkg.sv
// Shared definitions for the matrix-multiplier frame feeder.
package mm_frame_feeder_pkg;

    localparam int DW      = 8;
    localparam int HDR_M   = 0;
    localparam int HDR_N   = 1;
    localparam int HDR_LEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        STREAM,
        WAIT
    } state_t;

endpackage

// File: rtl/mm_frame_feeder_frame_buffer.sv
// Frame storage: one write port and one registered read port.
// The read register only advances when re is high, so it keeps the last byte read.
module mm_frame_feeder_frame_buffer #(
    parameter int DW    = mm_frame_feeder_pkg::DW,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [DEPTH];

    // Store incoming frame bytes; contents after reset are don't-care.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // Registered read; holds its value between streams and clears on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd <= '0;
        end else if (re) begin
            rd <= mem[ra];
        end
    end

endmodule

// File: rtl/mm_frame_feeder.sv
// Buffers one framed matrix pair from the host, validates its length and
// replays it gap-free to the multiplier, then waits for the multiplier's done.
module mm_frame_feeder #(
    parameter int DW    = mm_frame_feeder_pkg::DW,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hostValid,
    output logic          hostReady,
    input  logic [DW-1:0] hostData,
    input  logic          hostLast,
    output logic          start,
    output logic [DW-1:0] outData,
    output logic          outValid,
    input  logic          mulDone,
    output logic          busy,
    output logic          frameErr
);

    import mm_frame_feeder_pkg::*;

    localparam int LW = 2 * DW + 1;
    localparam int PW = AW + 1;

    state_t        state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          ovf;
    logic [DW-1:0] m_reg;
    logic [DW-1:0] n_reg;
    logic [LW-1:0] len;

    logic          accept;
    logic          at_full;
    logic [LW-1:0] count;
    logic          last_ok;
    logic          buf_we;
    logic [AW-1:0] buf_wa;
    logic          buf_re;

    assign hostReady = (state == IDLE) || (state == LOAD);
    assign busy      = (state != IDLE);
    assign accept    = hostValid && hostReady;
    assign at_full   = (wr_ptr == PW'(DEPTH));

    // Byte count of the frame including the byte being accepted now.
    assign count   = LW'(wr_ptr) + LW'(1);
    assign last_ok = (count == len) && (m_reg != '0) && (n_reg != '0) && !ovf && !at_full;

    assign buf_we = accept && ((state == IDLE) || !at_full);
    assign buf_wa = (state == IDLE) ? AW'(HDR_M) : wr_ptr[AW-1:0];

    // The read address runs one byte ahead of the byte currently on outData.
    assign buf_re = (state == START) || ((state == STREAM) && (LW'(rd_ptr) < len));

    mm_frame_feeder_frame_buffer #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) frame_buffer (
        .clk (clk),
        .rst (rst),
        .we  (buf_we),
        .wa  (buf_wa),
        .wd  (hostData),
        .re  (buf_re),
        .ra  (rd_ptr[AW-1:0]),
        .rd  (outData)
    );

    // Frame FSM: capture, length check, start pulse, replay and wait for done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ovf      <= 1'b0;
            m_reg    <= '0;
            n_reg    <= '0;
            len      <= '0;
            start    <= 1'b0;
            outValid <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            start    <= 1'b0;
            frameErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_reg <= hostData;
                        n_reg <= '0;
                        len   <= '0;
                        ovf   <= 1'b0;
                        if (hostLast) begin
                            frameErr <= 1'b1;
                            wr_ptr   <= '0;
                        end else begin
                            wr_ptr <= PW'(1);
                            state  <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (at_full) begin
                            ovf <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + PW'(1);
                        end
                        if (wr_ptr == PW'(HDR_N)) begin
                            n_reg <= hostData;
                            len   <= LW'(HDR_LEN) + ((LW'(m_reg) * LW'(hostData)) << 1);
                        end
                        if (hostLast) begin
                            if (last_ok) begin
                                state  <= START;
                                start  <= 1'b1;
                                rd_ptr <= '0;
                            end else begin
                                frameErr <= 1'b1;
                                wr_ptr   <= '0;
                                ovf      <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                    end
                end
                START: begin
                    state    <= STREAM;
                    outValid <= 1'b1;
                    rd_ptr   <= rd_ptr + PW'(1);
                end
                STREAM: begin
                    if (LW'(rd_ptr) == len) begin
                        state    <= WAIT;
                        outValid <= 1'b0;
                    end else begin
                        rd_ptr <= rd_ptr + PW'(1);
                    end
                end
                WAIT: begin
                    if (mulDone) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_frame_feeder.sv
// Self-checking bench for mm_frame_feeder: a cycle table for a basic frame
// plus directed sequences for gaps, rejections, overflow and reset.
module tb_mm_frame_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       hostValid;
    logic       hostReady;
    logic [7:0] hostData;
    logic       hostLast;
    logic       start;
    logic [7:0] outData;
    logic       outValid;
    logic       mulDone;
    logic       busy;
    logic       frameErr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       hostValid;
        logic [7:0] hostData;
        logic       hostLast;
        logic       mulDone;
        logic       expReady;
        logic       expStart;
        logic       expValid;
        logic [7:0] expData;
        logic       expBusy;
        logic       expErr;
    } vec_t;

    vec_t       vecs[25];
    logic [7:0] frameA[$];
    logic [7:0] frameQ[$];

    mm_frame_feeder #(
        .DW    (8),
        .DEPTH (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hostValid (hostValid),
        .hostReady (hostReady),
        .hostData  (hostData),
        .hostLast  (hostLast),
        .start     (start),
        .outData   (outData),
        .outValid  (outValid),
        .mulDone   (mulDone),
        .busy      (busy),
        .frameErr  (frameErr)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Guard against a stuck run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        hostValid = v.hostValid;
        hostData  = v.hostData;
        hostLast  = v.hostLast;
        mulDone   = v.mulDone;
    endtask

    task automatic idleInputs();
        hostValid = 1'b0;
        hostData  = 8'd0;
        hostLast  = 1'b0;
        mulDone   = 1'b0;
    endtask

    // Sends a frame; returns #1 after the edge that accepted the last byte.
    task automatic sendFrame(input logic [7:0] bytes[$], input bit gaps);
        for (int i = 0; i < bytes.size(); i++) begin
            hostValid = 1'b1;
            hostData  = bytes[i];
            hostLast  = (i == bytes.size() - 1);
            tick();
            if (gaps && (i != bytes.size() - 1)) begin
                hostValid = 1'b0;
                hostLast  = 1'b0;
                tick();
            end
        end
        idleInputs();
    endtask

    // Called in the START cycle: checks the pulse, the gap-free replay and the done handshake.
    task automatic streamCheck(input string name, input logic [7:0] bytes[$]);
        int extraStarts;
        extraStarts = 0;
        checkOutput($sformatf("%s start", name), 32'(start), 32'd1);
        checkOutput($sformatf("%s ready in START", name), 32'(hostReady), 32'd0);
        tick();
        for (int i = 0; i < bytes.size(); i++) begin
            checkOutput($sformatf("%s valid[%0d]", name, i), 32'(outValid), 32'd1);
            checkOutput($sformatf("%s data[%0d]", name, i), 32'(outData), 32'(bytes[i]));
            extraStarts += int'(start);
            tick();
        end
        checkOutput($sformatf("%s extra starts", name), 32'(extraStarts), 32'd0);
        checkOutput($sformatf("%s valid in WAIT", name), 32'(outValid), 32'd0);
        checkOutput($sformatf("%s busy in WAIT", name), 32'(busy), 32'd1);
        mulDone = 1'b1;
        tick();
        mulDone = 1'b0;
        checkOutput($sformatf("%s busy after done", name), 32'(busy), 32'd0);
        checkOutput($sformatf("%s ready after done", name), 32'(hostReady), 32'd1);
    endtask

    initial begin
        frameA = '{8'd2, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};

        // Cycle table for the basic frame: bytes in cycles 0-9, START in 10,
        // replay in 11-20, WAIT in 21-23 (done in 23), IDLE in 24.
        // Junk is offered while not ready and done is pulsed mid-stream.
        for (int k = 0; k < 25; k++) begin
            vecs[k].hostValid = (k <= 22);
            vecs[k].hostData  = (k <= 9) ? frameA[k] : 8'hEE;
            vecs[k].hostLast  = (k == 9);
            vecs[k].mulDone   = (k == 14) || (k == 23);
            vecs[k].expReady  = (k <= 9) || (k == 24);
            vecs[k].expStart  = (k == 10);
            vecs[k].expValid  = (k >= 11) && (k <= 20);
            vecs[k].expData   = (k <= 10) ? 8'd0 : ((k <= 20) ? frameA[k - 11] : 8'd8);
            vecs[k].expBusy   = (k >= 1) && (k <= 23);
            vecs[k].expErr    = 1'b0;
        end

        rst = 1'b0;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset hostReady", 32'(hostReady), 32'd1);
        checkOutput("reset start", 32'(start), 32'd0);
        checkOutput("reset outValid", 32'(outValid), 32'd0);
        checkOutput("reset outData", 32'(outData), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset frameErr", 32'(frameErr), 32'd0);
        checkOutput("reset wr_ptr", 32'(dut.wr_ptr), 32'd0);
        checkOutput("reset rd_ptr", 32'(dut.rd_ptr), 32'd0);
        checkOutput("reset ovf", 32'(dut.ovf), 32'd0);
        rst = 1'b1;

        for (int k = 0; k < 25; k++) begin
            applyStimulus(vecs[k]);
            checkOutput($sformatf("vec%0d hostReady", k), 32'(hostReady), 32'(vecs[k].expReady));
            checkOutput($sformatf("vec%0d start", k), 32'(start), 32'(vecs[k].expStart));
            checkOutput($sformatf("vec%0d outValid", k), 32'(outValid), 32'(vecs[k].expValid));
            checkOutput($sformatf("vec%0d outData", k), 32'(outData), 32'(vecs[k].expData));
            checkOutput($sformatf("vec%0d busy", k), 32'(busy), 32'(vecs[k].expBusy));
            checkOutput($sformatf("vec%0d frameErr", k), 32'(frameErr), 32'(vecs[k].expErr));
            tick();
        end
        idleInputs();

        // Same frame with the host valid only every other cycle.
        sendFrame(frameA, 1'b1);
        streamCheck("toggle", frameA);

        // Last flag one byte early: rejected, then a good frame still works.
        frameQ = frameA[0:8];
        sendFrame(frameQ, 1'b0);
        checkOutput("short frameErr", 32'(frameErr), 32'd1);
        checkOutput("short start", 32'(start), 32'd0);
        checkOutput("short busy", 32'(busy), 32'd0);
        checkOutput("short wr_ptr", 32'(dut.wr_ptr), 32'd0);
        tick();
        checkOutput("short frameErr pulse", 32'(frameErr), 32'd0);
        checkOutput("short no start", 32'(start), 32'd0);
        checkOutput("short no outValid", 32'(outValid), 32'd0);
        sendFrame(frameA, 1'b0);
        streamCheck("after short", frameA);

        // Single-byte frame ends in IDLE.
        frameQ = '{8'd2};
        sendFrame(frameQ, 1'b0);
        checkOutput("single frameErr", 32'(frameErr), 32'd1);
        checkOutput("single busy", 32'(busy), 32'd0);
        checkOutput("single start", 32'(start), 32'd0);
        tick();

        // Zero dimension: length matches but M is zero.
        frameQ = '{8'd0, 8'd3};
        sendFrame(frameQ, 1'b0);
        checkOutput("zero-dim frameErr", 32'(frameErr), 32'd1);
        checkOutput("zero-dim start", 32'(start), 32'd0);
        tick();

        // M=6, N=6 needs 74 bytes and overflows the 64-entry buffer.
        for (int i = 0; i < 74; i++) begin
            hostValid = 1'b1;
            hostData  = (i < 2) ? 8'd6 : 8'(i);
            hostLast  = (i == 73);
            tick();
            if (i == 64) begin
                checkOutput("ovf set", 32'(dut.ovf), 32'd1);
                checkOutput("wr_ptr saturated", 32'(dut.wr_ptr), 32'd64);
            end
        end
        idleInputs();
        checkOutput("ovf frameErr", 32'(frameErr), 32'd1);
        checkOutput("ovf start", 32'(start), 32'd0);
        checkOutput("ovf wr_ptr cleared", 32'(dut.wr_ptr), 32'd0);
        checkOutput("ovf cleared", 32'(dut.ovf), 32'd0);
        tick();

        // M=1, N=31 fills the buffer exactly (L = 64).
        frameQ = '{8'd1, 8'd31};
        for (int i = 0; i < 62; i++) begin
            frameQ.push_back(8'(i * 5 + 1));
        end
        sendFrame(frameQ, 1'b0);
        checkOutput("full frameErr", 32'(frameErr), 32'd0);
        streamCheck("full", frameQ);

        // Reset in the middle of a replay abandons the frame.
        sendFrame(frameA, 1'b0);
        checkOutput("rst-mid start", 32'(start), 32'd1);
        tick();
        tick();
        tick();
        checkOutput("rst-mid streaming", 32'(outValid), 32'd1);
        checkOutput("rst-mid data", 32'(outData), 32'(frameA[2]));
        rst = 1'b0;
        #1;
        checkOutput("rst-mid outValid", 32'(outValid), 32'd0);
        checkOutput("rst-mid start low", 32'(start), 32'd0);
        checkOutput("rst-mid hostReady", 32'(hostReady), 32'd1);
        checkOutput("rst-mid busy", 32'(busy), 32'd0);
        checkOutput("rst-mid outData", 32'(outData), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sendFrame(frameA, 1'b0);
        streamCheck("after reset", frameA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
